// File: rtl/cube_root_pkg.sv
// Shared definitions for the integer cube-root sequencer: default widths and FSM state encodings.
// Imported by the datapath top and by the front-end/display modules that talk to it.
package cube_root_pkg;

  // Root width needed to cover a w-bit operand: ceil(w/3).
  function automatic int root_width(input int w);
    return (w + 2) / 3;
  endfunction

  localparam int DEF_WIDTH = 20;
  localparam int DEF_RES_W = root_width(DEF_WIDTH);

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_SQ   = 3'd1;
  localparam logic [ST_W-1:0] ST_CUBE = 3'd2;
  localparam logic [ST_W-1:0] ST_CMP  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/cube_root_seq.sv
// Bit-serial integer cube root: one root bit per square/cube/compare pass, MSB first.
// Owns the start/abort handshake with re-arm, and presents root/exact with a one-cycle done.
module cube_root_seq
  import cube_root_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RES_W = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] root,
  output logic             exact
);

  localparam int SQ_W   = 2 * RES_W;
  localparam int CUBE_W = 3 * RES_W;
  localparam int IDX_W  = (RES_W > 1) ? $clog2(RES_W) : 1;

  logic [ST_W-1:0]   state;
  logic [WIDTH-1:0]  op;
  logic [RES_W-1:0]  trial;
  logic [IDX_W-1:0]  idx;
  logic [SQ_W-1:0]   sq;
  logic [CUBE_W-1:0] cube;
  logic              eq;
  logic              armed;

  logic [RES_W-1:0]  cand;
  logic [CUBE_W-1:0] op_ext;
  logic              fits;
  logic [RES_W-1:0]  next_trial;
  logic              next_eq;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    cand       = trial | (RES_W'(1) << idx);
    op_ext     = CUBE_W'(op);
    fits       = (cube <= op_ext);
    next_trial = fits ? cand : trial;
    next_eq    = eq | (cube == op_ext);
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= '0;
      trial <= '0;
      idx   <= '0;
      sq    <= '0;
      cube  <= '0;
      eq    <= 1'b0;
      armed <= 1'b1;
      root  <= '0;
      exact <= 1'b0;
    end else begin
      // Re-arm whenever start is released; a held start therefore launches one run only.
      if (!start) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start && armed && !abort) begin
            op    <= operand;
            trial <= '0;
            idx   <= IDX_W'(RES_W - 1);
            eq    <= (operand == '0);
            armed <= 1'b0;
            state <= ST_SQ;
          end
        end

        ST_SQ: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            sq    <= SQ_W'(cand) * SQ_W'(cand);
            state <= ST_CUBE;
          end
        end

        ST_CUBE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cube  <= CUBE_W'(sq) * CUBE_W'(cand);
            state <= ST_CMP;
          end
        end

        ST_CMP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            trial <= next_trial;
            eq    <= next_eq;
            // Results are registered on the last compare so they are valid while done is high.
            if (idx == '0) begin
              root  <= next_trial;
              exact <= next_eq;
              state <= ST_DONE;
            end else begin
              idx   <= idx - IDX_W'(1);
              state <= ST_SQ;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SQ) || (state == ST_CUBE) || (state == ST_CMP);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_cube_root_seq.sv
// Directed bench for cube_root_seq: table of operands with hand-computed roots, plus
// abort, held-start, re-arm and mid-run reset sequences.
module tb_cube_root_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [19:0] operand;
  logic        busy;
  logic        done;
  logic [6:0]  root;
  logic        exact;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [19:0] operand;
    logic [6:0]  root;
    logic        exact;
  } vec_t;

  vec_t vecs[11];

  cube_root_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .root    (root),
    .exact   (exact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one run with a single-cycle start and check latency, busy window and result.
  task automatic run_op(input string name, input logic [19:0] v,
                        input logic [6:0] exp_root, input logic exp_exact);
    int lat;
    int busy_bad;
    lat      = 0;
    busy_bad = 0;
    operand  = v;
    start    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_bad++;
    end
    check({name, " latency"}, lat, 22);
    check({name, " busy window"}, busy_bad, 0);
    check({name, " busy at done"}, int'(busy), 0);
    check({name, " root"}, int'(root), int'(exp_root));
    check({name, " exact"}, int'(exact), int'(exp_exact));
    tick();
    check({name, " done one cycle"}, int'(done), 0);
  endtask

  // Count done pulses over a fixed window.
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) n++;
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{"op27",      20'd27,      7'd3,   1'b1};
    vecs[1]  = '{"op26",      20'd26,      7'd2,   1'b0};
    vecs[2]  = '{"op0",       20'd0,       7'd0,   1'b1};
    vecs[3]  = '{"opmax",     20'd1048575, 7'd101, 1'b0};
    vecs[4]  = '{"op999999",  20'd999999,  7'd99,  1'b0};
    vecs[5]  = '{"op1",       20'd1,       7'd1,   1'b1};
    vecs[6]  = '{"op7",       20'd7,       7'd1,   1'b0};
    vecs[7]  = '{"op8",       20'd8,       7'd2,   1'b1};
    vecs[8]  = '{"op1000",    20'd1000,    7'd10,  1'b1};
    vecs[9]  = '{"op970299",  20'd970299,  7'd99,  1'b1};
    vecs[10] = '{"op970298",  20'd970298,  7'd98,  1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    operand = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    check("reset root",  int'(root),  0);
    check("reset exact", int'(exact), 0);
    tick();

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].operand, vecs[i].root, vecs[i].exact);

    // Abort mid-run: previous result (27 -> 3, exact) must survive.
    run_op("pre-abort", 20'd27, 7'd3, 1'b1);
    operand = 20'd1000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy drop", int'(busy), 0);
    count_done(30, n);
    check("abort no done", n, 0);
    check("abort root kept", int'(root), 3);
    check("abort exact kept", int'(exact), 1);

    // Abort in IDLE wins over start; the still-armed start is accepted once abort drops.
    operand = 20'd64;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    check("idle abort blocks", int'(busy), 0);
    abort = 1'b0;
    tick();
    start = 1'b0;
    check("accept after abort", int'(busy), 1);
    count_done(30, n);
    check("post-abort run done", n, 1);
    check("post-abort run root", int'(root), 4);

    // Held start yields exactly one run.
    operand = 20'd343;
    start   = 1'b1;
    count_done(60, n);
    check("held start one done", n, 1);
    check("held start root", int'(root), 7);
    check("held start idle", int'(busy), 0);
    start = 1'b0;
    tick();
    run_op("rearm", 20'd125, 7'd5, 1'b1);

    // Reset mid-run clears everything and no done appears.
    operand = 20'd999999;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset busy",  int'(busy),  0);
    check("midreset done",  int'(done),  0);
    check("midreset root",  int'(root),  0);
    check("midreset exact", int'(exact), 0);
    count_done(30, n);
    check("midreset no done", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
